// File: rtl/seq_array_multiplier.sv
// Sequential shift-add multiplier: one partial-product row per clock, valid/ready on both sides.
// Define MULT_SIGNED_EN to add the per-operation signed_mode port (two's complement).
module seq_array_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef MULT_SIGNED_EN
  input  logic               signed_mode,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int PW    = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sgn_q, sgn_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [PW-1:0]    product_q, product_d;

  logic             op_sgn;
  logic             last;
  logic [PW-1:0]    pp;

`ifdef MULT_SIGNED_EN
  assign op_sgn = signed_mode;
`else
  assign op_sgn = 1'b0;
`endif

  assign last = (cnt_q == CNT_W'(WIDTH - 1));
  assign pp   = a_q << cnt_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    a_d         = a_q;
    b_d         = b_q;
    sgn_d       = sgn_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    product_d   = product_q;
    unique case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          a_d        = op_sgn ? {{WIDTH{a[WIDTH-1]}}, a}
                              : {{WIDTH{1'b0}}, a};
          b_d        = b;
          sgn_d      = op_sgn;
          acc_d      = '0;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = CALC;
        end
      end
      CALC: begin
        // Top multiplier bit carries negative weight in signed mode.
        if (b_q[cnt_q]) begin
          acc_d = (last && sgn_q) ? acc_q - pp : acc_q + pp;
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (last) begin
          cnt_d       = '0;
          out_valid_d = 1'b1;
          product_d   = acc_d;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sgn_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      product_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sgn_q       <= sgn_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      product_q   <= product_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign product   = product_q;

endmodule
